// File: rtl/ppu_vec_pkg.sv
// Shared definitions for the post-processing unit: default widths and the
// packet-tracking state type.
package ppu_pkg;

    localparam int LANES_D   = 4;
    localparam int ACC_W_D   = 32;
    localparam int OUT_W_D   = 8;
    localparam int SHIFT_W_D = 6;
    localparam int CNT_W_D   = 16;

    typedef enum logic {
        IDLE   = 1'b0,
        IN_PKT = 1'b1
    } pkt_state_t;

endpackage

// File: rtl/ppu_vec_if.sv
// Stream bundle for the post-processing unit: accumulator beats in,
// activation beats out, plus the per-packet saturation count.
interface ppu_vec_if
    import ppu_pkg::*;
#(
    parameter int LANES = LANES_D,
    parameter int ACC_W = ACC_W_D,
    parameter int OUT_W = OUT_W_D,
    parameter int CNT_W = CNT_W_D
);

    logic                   in_valid;
    logic                   in_ready;
    logic [LANES*ACC_W-1:0] in_data;
    logic                   in_last;
    logic                   out_valid;
    logic                   out_ready;
    logic [LANES*OUT_W-1:0] out_data;
    logic                   out_last;
    logic [CNT_W-1:0]       out_sat_cnt;

    // Producer of accumulator beats and consumer of activations
    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_last, out_sat_cnt
    );

    // The post-processing unit itself
    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_last, out_sat_cnt
    );

endinterface

// File: rtl/ppu_vec_lane.sv
// Combinational per-lane datapath. The s1_* half does ReLU, optional
// round-half-up and the arithmetic right shift; the s2_* half adds the zero
// point and clamps into the unsigned output range, flagging saturation.
module ppu_lane
    import ppu_pkg::*;
#(
    parameter int ACC_W   = ACC_W_D,
    parameter int OUT_W   = OUT_W_D,
    parameter int SHIFT_W = SHIFT_W_D
) (
    input  logic signed [ACC_W-1:0] s1_x,
    input  logic                    s1_relu_en,
    input  logic                    s1_round_en,
    input  logic [SHIFT_W-1:0]      s1_shift,
    output logic signed [ACC_W-1:0] s1_y,
    input  logic signed [ACC_W-1:0] s2_y,
    input  logic [OUT_W-1:0]        s2_zero_point,
    output logic [OUT_W-1:0]        s2_out,
    output logic                    s2_sat
);

    localparam logic [SHIFT_W:0]        SHIFT_LIM = (SHIFT_W+1)'(ACC_W);
    localparam logic signed [ACC_W+1:0] OUT_MAX   = (ACC_W+2)'((1 << OUT_W) - 1);

    // Rounded arithmetic shift; one extra bit keeps the rounding bias from
    // overflowing. Shifts of ACC_W or more collapse to the sign.
    function automatic logic signed [ACC_W-1:0] round_shift(
        input logic signed [ACC_W-1:0] x,
        input logic                    round_en,
        input logic [SHIFT_W-1:0]      shift
    );
        logic signed [ACC_W:0] xe;
        logic signed [ACC_W:0] bias;
        logic signed [ACC_W:0] xb;
        logic signed [ACC_W:0] xs;
        xe   = {x[ACC_W-1], x};
        bias = '0;
        if ({1'b0, shift} >= SHIFT_LIM) begin
            return x[ACC_W-1] ? '1 : '0;
        end
        if (round_en && (shift != '0)) begin
            bias = (ACC_W+1)'(1) << (shift - SHIFT_W'(1));
        end
        xb = xe + bias;
        xs = xb >>> shift;
        return xs[ACC_W-1:0];
    endfunction

    // Zero-point add and clamp; returns {sat, value}
    function automatic logic [OUT_W:0] clamp_zp(
        input logic signed [ACC_W-1:0] y,
        input logic [OUT_W-1:0]        zp
    );
        logic signed [ACC_W+1:0] z;
        z = {{2{y[ACC_W-1]}}, y} + {{(ACC_W+2-OUT_W){1'b0}}, zp};
        if (z[ACC_W+1]) begin
            return {1'b1, {OUT_W{1'b0}}};
        end
        if (z > OUT_MAX) begin
            return {1'b1, {OUT_W{1'b1}}};
        end
        return {1'b0, z[OUT_W-1:0]};
    endfunction

    logic signed [ACC_W-1:0] x_relu;

    // First half: ReLU then rounded shift
    always_comb begin
        x_relu = (s1_relu_en && s1_x[ACC_W-1]) ? '0 : s1_x;
        s1_y   = round_shift(x_relu, s1_round_en, s1_shift);
    end

    // Second half: zero point and clamp
    always_comb begin
        {s2_sat, s2_out} = clamp_zp(s2_y, s2_zero_point);
    end

endmodule

// File: rtl/ppu_vec.sv
// Multi-lane post-processing unit: two-stage pipeline with valid/ready on
// both sides, packet-scoped configuration capture and a saturating count of
// clamped lanes reported with the last beat of each packet.
module ppu_vec
    import ppu_pkg::*;
#(
    parameter int LANES   = LANES_D,
    parameter int ACC_W   = ACC_W_D,
    parameter int OUT_W   = OUT_W_D,
    parameter int SHIFT_W = SHIFT_W_D,
    parameter int CNT_W   = CNT_W_D
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_relu_en,
    input  logic               cfg_round_en,
    input  logic [SHIFT_W-1:0] cfg_shift,
    input  logic [OUT_W-1:0]   cfg_zero_point,
    ppu_vec_if.slave           bus
);

    function automatic logic [CNT_W-1:0] cnt_sat_add(
        input logic [CNT_W-1:0] a,
        input logic [CNT_W-1:0] b
    );
        logic [CNT_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[CNT_W] ? '1 : s[CNT_W-1:0];
    endfunction

    function automatic logic [CNT_W-1:0] popcount(input logic [LANES-1:0] f);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < LANES; i++) begin
            c = c + CNT_W'(f[i]);
        end
        return c;
    endfunction

    pkt_state_t state_q, state_d;
    logic       cfg_capture, use_live;

    logic               relu_q, round_q;
    logic [SHIFT_W-1:0] shift_q;
    logic [OUT_W-1:0]   zp_q;
    logic               relu_cur, round_cur;
    logic [SHIFT_W-1:0] shift_cur;
    logic [OUT_W-1:0]   zp_cur;

    logic s2_adv, s1_adv, in_fire, out_fire;

    logic                    vld_p1, last_p1;
    logic [OUT_W-1:0]        zp_p1;
    logic signed [ACC_W-1:0] y_s1 [LANES];
    logic signed [ACC_W-1:0] y_p1 [LANES];

    logic [OUT_W-1:0]       o_s2 [LANES];
    logic [LANES-1:0]       sat_s2;
    logic                   vld_p2, last_p2;
    logic [LANES-1:0]       sat_p2;
    logic [LANES*OUT_W-1:0] data_p2;

    logic [CNT_W-1:0] cnt_q, pop_p2, cnt_with_beat;

    // Handshake: a stage advances when it is empty or its successor advances
    always_comb begin
        s2_adv   = !vld_p2 || bus.out_ready;
        s1_adv   = !vld_p1 || s2_adv;
        in_fire  = bus.in_valid && s1_adv;
        out_fire = vld_p2 && bus.out_ready;
    end

    // Packet state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Packet next-state: leave IDLE on a non-last beat, return on a last beat
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_fire && !bus.in_last) state_d = IN_PKT;
            IN_PKT:  if (in_fire && bus.in_last)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Packet outputs: first beat uses live cfg and latches it for the rest
    always_comb begin
        use_live    = (state_q == IDLE);
        cfg_capture = use_live && in_fire;
    end

    // Configuration capture at the first beat of a packet
    always_ff @(posedge clk) begin
        if (cfg_capture) begin
            relu_q  <= cfg_relu_en;
            round_q <= cfg_round_en;
            shift_q <= cfg_shift;
            zp_q    <= cfg_zero_point;
        end
    end

    // Configuration seen by the beat currently at the input
    always_comb begin
        relu_cur  = use_live ? cfg_relu_en    : relu_q;
        round_cur = use_live ? cfg_round_en   : round_q;
        shift_cur = use_live ? cfg_shift      : shift_q;
        zp_cur    = use_live ? cfg_zero_point : zp_q;
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        ppu_lane #(
            .ACC_W   (ACC_W),
            .OUT_W   (OUT_W),
            .SHIFT_W (SHIFT_W)
        ) u_lane (
            .s1_x          (bus.in_data[g*ACC_W +: ACC_W]),
            .s1_relu_en    (relu_cur),
            .s1_round_en   (round_cur),
            .s1_shift      (shift_cur),
            .s1_y          (y_s1[g]),
            .s2_y          (y_p1[g]),
            .s2_zero_point (zp_p1),
            .s2_out        (o_s2[g]),
            .s2_sat        (sat_s2[g])
        );
    end

    // ---- Stage S1 boundary: shifted lanes plus the packet's zero point ----
    always_ff @(posedge clk) begin
        if (rst)         vld_p1 <= 1'b0;
        else if (s1_adv) vld_p1 <= bus.in_valid;
    end

    // S1 data loads only on an accepted beat
    always_ff @(posedge clk) begin
        if (in_fire) begin
            for (int i = 0; i < LANES; i++) y_p1[i] <= y_s1[i];
            zp_p1   <= zp_cur;
            last_p1 <= bus.in_last;
        end
    end

    // ---- Stage S2 boundary: clamped activations and saturation flags ----
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p2  <= 1'b0;
            last_p2 <= 1'b0;
            sat_p2  <= '0;
            data_p2 <= '0;
        end else if (s2_adv) begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                last_p2 <= last_p1;
                sat_p2  <= sat_s2;
                for (int i = 0; i < LANES; i++) data_p2[i*OUT_W +: OUT_W] <= o_s2[i];
            end
        end
    end

    // Running count including the beat currently presented
    always_comb begin
        pop_p2        = popcount(sat_p2);
        cnt_with_beat = cnt_sat_add(cnt_q, pop_p2);
    end

    // Per-packet saturation counter, cleared once the last beat is taken
    always_ff @(posedge clk) begin
        if (rst)           cnt_q <= '0;
        else if (out_fire) cnt_q <= last_p2 ? '0 : cnt_with_beat;
    end

    assign bus.in_ready    = s1_adv;
    assign bus.out_valid   = vld_p2;
    assign bus.out_data    = data_p2;
    assign bus.out_last    = vld_p2 && last_p2;
    assign bus.out_sat_cnt = (vld_p2 && last_p2) ? cnt_with_beat : '0;

endmodule

// File: tb/tb_ppu_vec.sv
// Self-checking bench for ppu_vec: directed scenarios plus randomized packets
// compared against an arithmetic reference model with a beat scoreboard.
module tb_ppu_vec;
    import ppu_pkg::*;

    localparam int LANES   = 4;
    localparam int ACC_W   = 32;
    localparam int OUT_W   = 8;
    localparam int SHIFT_W = 6;
    localparam int CNT_W   = 16;
    localparam longint OMAX = (64'sd1 <<< OUT_W) - 1;
    localparam longint CMAX = (64'sd1 <<< CNT_W) - 1;

    logic               clk = 1'b0;
    logic               rst;
    logic               cfg_relu_en, cfg_round_en;
    logic [SHIFT_W-1:0] cfg_shift;
    logic [OUT_W-1:0]   cfg_zero_point;

    ppu_vec_if #(.LANES(LANES), .ACC_W(ACC_W), .OUT_W(OUT_W), .CNT_W(CNT_W)) bus ();

    ppu_vec #(
        .LANES(LANES), .ACC_W(ACC_W), .OUT_W(OUT_W), .SHIFT_W(SHIFT_W), .CNT_W(CNT_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .cfg_relu_en    (cfg_relu_en),
        .cfg_round_en   (cfg_round_en),
        .cfg_shift      (cfg_shift),
        .cfg_zero_point (cfg_zero_point),
        .bus            (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference conversion of one lane straight from the arithmetic rules
    function automatic longint ref_lane(input longint xin, input bit relu, input bit rnd,
                                        input int sh, input longint zp, output bit sat);
        longint x, y, z;
        x = xin;
        if (relu && x < 0) x = 0;
        if (sh >= ACC_W) begin
            y = (x < 0) ? -1 : 0;
        end else begin
            if (rnd && sh > 0) x = x + (64'sd1 <<< (sh - 1));
            y = x >>> sh;
        end
        z   = y + zp;
        sat = 1'b0;
        if (z < 0)    begin sat = 1'b1; return 0;    end
        if (z > OMAX) begin sat = 1'b1; return OMAX; end
        return z;
    endfunction

    typedef struct {
        logic [LANES*OUT_W-1:0] data;
        bit                     last;
        int                     pop;
    } exp_t;

    exp_t   q[$];
    bit     m_idle = 1'b1;
    bit     m_relu, m_round;
    int     m_shift;
    longint m_zp;
    longint m_run = 0;
    bit     prev_stall = 1'b0;
    logic [LANES*OUT_W-1:0] prev_data;

    // Scoreboard: model every accepted beat, compare every delivered beat
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            m_idle     = 1'b1;
            m_run      = 0;
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", bus.out_valid, 1'b1);
                chk("hold_data", bus.out_data, prev_data);
            end
            if (bus.out_valid && bus.out_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_beat", bus.out_valid, 1'b0);
                end else begin
                    exp_t   e;
                    longint tot, ecnt;
                    e   = q.pop_front();
                    tot = m_run + e.pop;
                    if (tot > CMAX) tot = CMAX;
                    ecnt = e.last ? tot : 0;
                    m_run = e.last ? 0 : tot;
                    chk("sb_data", bus.out_data, e.data);
                    chk("sb_last", bus.out_last, e.last);
                    chk("sb_sat_cnt", bus.out_sat_cnt, ecnt);
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                exp_t e;
                if (m_idle) begin
                    m_relu  = cfg_relu_en;
                    m_round = cfg_round_en;
                    m_shift = int'(cfg_shift);
                    m_zp    = longint'(cfg_zero_point);
                end
                e.pop = 0;
                for (int i = 0; i < LANES; i++) begin
                    logic signed [ACC_W-1:0] xl;
                    bit s;
                    longint o;
                    xl = bus.in_data[i*ACC_W +: ACC_W];
                    o  = ref_lane(longint'(xl), m_relu, m_round, m_shift, m_zp, s);
                    e.data[i*OUT_W +: OUT_W] = o[OUT_W-1:0];
                    e.pop += int'(s);
                end
                e.last = bus.in_last;
                q.push_back(e);
                m_idle = bus.in_last;
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_data  = bus.out_data;
        end
    end

    function automatic logic [LANES*ACC_W-1:0] pack(input int a, input int b, input int c, input int d);
        return {32'(d), 32'(c), 32'(b), 32'(a)};
    endfunction

    function automatic logic [LANES*ACC_W-1:0] rand_data();
        logic [LANES*ACC_W-1:0] r;
        for (int i = 0; i < LANES; i++) begin
            logic signed [ACC_W-1:0] v;
            v = $urandom;
            v = v >>> $urandom_range(0, 31);
            r[i*ACC_W +: ACC_W] = v;
        end
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one beat and hold it until the DUT takes it
    task automatic send(input logic [LANES*ACC_W-1:0] d, input bit last);
        int n;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = last;
        n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("send_timeout", bus.in_ready, 1'b1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    // Wait for a last beat at the output; checks its data and count
    task automatic wait_last(input string tag, input logic [LANES*OUT_W-1:0] ed, input int ec);
        int n;
        n = 0;
        @(negedge clk);
        while (!(bus.out_valid && bus.out_last) && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_last"}, bus.out_last, 1'b1);
        chk({tag, "_data"}, bus.out_data, ed);
        chk({tag, "_cnt"}, bus.out_sat_cnt, ec);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 500) begin
            step();
            n++;
        end
        chk("drain", q.size(), 0);
    endtask

    task automatic set_cfg(input bit relu, input bit rnd, input int sh, input int zp);
        cfg_relu_en    = relu;
        cfg_round_en   = rnd;
        cfg_shift      = SHIFT_W'(sh);
        cfg_zero_point = OUT_W'(zp);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    bit done;

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;
        set_cfg(0, 0, 0, 0);
        repeat (3) step();
        @(negedge clk);
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_out_data", bus.out_data, '0);
        chk("rst_out_cnt", bus.out_sat_cnt, '0);
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", bus.in_ready, 1'b1);
        chk("post_rst_out_last", bus.out_last, 1'b0);
        step();

        // Basic conversion with a two-cycle latency check
        set_cfg(1, 0, 4, 128);
        send(pack(32'h100, -32'sh100, 32'h10, 32'h7FFF), 1'b1);
        @(negedge clk);
        chk("lat_cycle1_valid", bus.out_valid, 1'b0);
        @(negedge clk);
        chk("lat_cycle2_valid", bus.out_valid, 1'b1);
        chk("basic_data", bus.out_data, 32'hFF818090);
        chk("basic_cnt", bus.out_sat_cnt, 1);
        drain();

        // No ReLU: only the -0x1000 lane clamps; 0x7F0>>4 + 128 = 255 fits
        set_cfg(0, 0, 4, 128);
        send(pack(-32'sh100, -32'sh1000, 0, 32'h7F0), 1'b1);
        wait_last("norelu", 32'hFF800070, 1);
        drain();

        // Rounding behaviour
        set_cfg(0, 1, 2, 0);
        send(pack(6, 5, 2, 1), 1'b1);
        wait_last("round_on", 32'h00010102, 0);
        set_cfg(0, 0, 2, 0);
        send(pack(6, 5, 2, 1), 1'b1);
        wait_last("round_off", 32'h00000101, 0);
        set_cfg(0, 1, 0, 0);
        send(pack(6, 5, 2, 1), 1'b1);
        wait_last("round_sh0", 32'h01020506, 0);
        drain();

        // Backpressure: two 4-beat packets streamed into a stalled output
        set_cfg(0, 1, 8, 100);
        bus.out_ready = 1'b0;
        fork
            begin
                for (int p = 0; p < 2; p++)
                    for (int b = 0; b < 4; b++) send(rand_data(), b == 3);
            end
            begin
                @(posedge clk);
                @(posedge clk);
                @(negedge clk);
                chk("bp_in_ready_low", bus.in_ready, 1'b0);
                chk("bp_out_valid", bus.out_valid, 1'b1);
                repeat (3) @(posedge clk);
                #1;
                bus.out_ready = 1'b1;
                for (int i = 0; i < 8; i++) begin
                    @(negedge clk);
                    chk("bp_one_per_cycle", bus.out_valid, 1'b1);
                end
            end
        join
        drain();

        // Config freeze: shift change mid-packet applies only to next packet
        set_cfg(0, 0, 4, 50);
        send(pack(32'h160, 32'h200, -32'sh40, 32'h10), 1'b0);
        cfg_shift = 0;
        send(pack(32'h160, 32'h200, -32'sh40, 32'h10), 1'b0);
        send(pack(32'h160, 32'h200, -32'sh40, 32'h10), 1'b1);
        wait_last("freeze_beat3", 32'h332E5248, 0);
        send(pack(5, 10, 0, -10), 1'b1);
        wait_last("freeze_next", 32'h28323C37, 0);
        drain();

        // Reset with two beats in flight
        set_cfg(0, 0, 3, 20);
        bus.out_ready = 1'b0;
        send(pack(-32'sh7000, 32'h7000, -32'sh7000, 32'h7000), 1'b0);
        send(pack(-32'sh7000, 32'h7000, -32'sh7000, 32'h7000), 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("midrst_out_valid", bus.out_valid, 1'b0);
        chk("midrst_in_ready", bus.in_ready, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("midrst_no_last", bus.out_last, 1'b0);
        end
        step();
        set_cfg(0, 0, 0, 0);
        send(pack(-5, 300, 7, 1000), 1'b1);
        wait_last("midrst_fresh", 32'hFF07FF00, 3);
        drain();

        // Randomized packets, random cfg, random mid-packet cfg noise, random stalls
        done = 1'b0;
        fork
            begin
                for (int p = 0; p < 25; p++) begin
                    int len;
                    len = $urandom_range(1, 5);
                    set_cfg($urandom_range(0, 1), $urandom_range(0, 1),
                            ($urandom_range(0, 7) == 0) ? $urandom_range(32, 63) : $urandom_range(0, 20),
                            $urandom_range(0, 255));
                    for (int b = 0; b < len; b++) begin
                        send(rand_data(), b == len - 1);
                        if (b != len - 1 && $urandom_range(0, 1) == 1)
                            set_cfg($urandom_range(0, 1), $urandom_range(0, 1),
                                    $urandom_range(0, 63), $urandom_range(0, 255));
                    end
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    step();
                    bus.out_ready = ($urandom_range(0, 3) != 0);
                end
                bus.out_ready = 1'b1;
            end
        join
        drain();
        @(negedge clk);
        chk("final_idle", bus.out_valid, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
